// File: rtl/ofs_plat_host_chan_xgroupx_fiu_stub_responder_if.sv
// Request/response signal bundle between an AFU (master) and the FIU stub responder (slave).
// Request fields flow master->slave; responses, almost-full and the error flag flow back.
interface ofs_plat_host_chan_xgroupx_fiu_stub_responder_if;
  logic         c0_req_valid;
  logic [41:0]  c0_req_addr;
  logic [1:0]   c0_req_cl_len;
  logic [15:0]  c0_req_mdata;
  logic         c1_req_valid;
  logic         c1_req_sop;
  logic [1:0]   c1_req_cl_len;
  logic [15:0]  c1_req_mdata;
  logic         c0_tx_alm_full;
  logic         c1_tx_alm_full;
  logic         c0_rsp_valid;
  logic [15:0]  c0_rsp_mdata;
  logic [1:0]   c0_rsp_cl_num;
  logic [511:0] c0_rsp_data;
  logic         c1_rsp_valid;
  logic [15:0]  c1_rsp_mdata;
  logic [1:0]   c1_rsp_cl_num;
  logic         err_overflow;

  modport master (
    output c0_req_valid, c0_req_addr, c0_req_cl_len, c0_req_mdata,
    output c1_req_valid, c1_req_sop, c1_req_cl_len, c1_req_mdata,
    input  c0_tx_alm_full, c1_tx_alm_full,
    input  c0_rsp_valid, c0_rsp_mdata, c0_rsp_cl_num, c0_rsp_data,
    input  c1_rsp_valid, c1_rsp_mdata, c1_rsp_cl_num, err_overflow
  );

  modport slave (
    input  c0_req_valid, c0_req_addr, c0_req_cl_len, c0_req_mdata,
    input  c1_req_valid, c1_req_sop, c1_req_cl_len, c1_req_mdata,
    output c0_tx_alm_full, c1_tx_alm_full,
    output c0_rsp_valid, c0_rsp_mdata, c0_rsp_cl_num, c0_rsp_data,
    output c1_rsp_valid, c1_rsp_mdata, c1_rsp_cl_num, err_overflow
  );
endinterface

// File: rtl/ofs_plat_host_chan_xgroupx_fiu_stub_responder.sv
// FIU-side stub: queues AFU c0 reads and c1 writes and answers them after a fixed latency
// with synthetic read data ({8{addr+cl_num}}) and packed write acks. No backing memory.
module ofs_plat_host_chan_xgroupx_fiu_stub_responder #(
  parameter int unsigned RSP_LATENCY = 8,
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter int unsigned ALM_FULL_TH = 8
) (
  input logic clk,
  input logic reset_n,
  ofs_plat_host_chan_xgroupx_fiu_stub_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [15:0]   LAT_C   = 16'(RSP_LATENCY);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] TH_C    = CW'(ALM_FULL_TH);

  typedef struct packed {
    logic [41:0] addr;
    logic [1:0]  len;
    logic [15:0] mdata;
    logic [15:0] due;
  } rd_ent_t;

  typedef struct packed {
    logic [15:0] mdata;
    logic [1:0]  len;
    logic [15:0] due;
  } wr_ent_t;

  typedef enum logic [0:0] {StIdle, StBurst} exp_state_e;

  // Free-running time base; due checks use signed difference so wrap is harmless.
  logic [15:0] r_now;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_now <= '0;
    else          r_now <= r_now + 16'd1;
  end

  // ---------------------------------------------------------------------------------------
  // Read request FIFO
  // ---------------------------------------------------------------------------------------
  rd_ent_t        r_rd_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_rd_wptr, r_rd_rptr;
  logic [CW-1:0]  r_rd_cnt;
  logic           w_rd_full, w_rd_empty, w_rd_push, w_rd_pop, w_rd_due, w_rd_bad_len;
  logic [1:0]     w_rd_len;
  rd_ent_t        w_rd_head, w_rd_new;
  logic signed [15:0] w_rd_diff;
  logic [CW-1:0]  w_rd_free;

  assign w_rd_full    = (r_rd_cnt == DEPTH_C);
  assign w_rd_empty   = (r_rd_cnt == '0);
  assign w_rd_bad_len = bus.c0_req_valid && (bus.c0_req_cl_len == 2'd2);
  assign w_rd_len     = (bus.c0_req_cl_len == 2'd2) ? 2'd0 : bus.c0_req_cl_len;
  assign w_rd_push    = bus.c0_req_valid && !w_rd_full;
  assign w_rd_new     = '{addr: bus.c0_req_addr, len: w_rd_len, mdata: bus.c0_req_mdata,
                          due: r_now + LAT_C};
  assign w_rd_head    = r_rd_mem[r_rd_rptr];
  assign w_rd_diff    = r_now - w_rd_head.due;
  assign w_rd_due     = !w_rd_empty && (w_rd_diff >= 0);
  assign w_rd_free    = DEPTH_C - r_rd_cnt;

  always_ff @(posedge clk) begin
    if (w_rd_push) r_rd_mem[r_rd_wptr] <= w_rd_new;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_wptr <= '0;
      r_rd_rptr <= '0;
      r_rd_cnt  <= '0;
    end else begin
      if (w_rd_push) r_rd_wptr <= r_rd_wptr + AW'(1);
      if (w_rd_pop)  r_rd_rptr <= r_rd_rptr + AW'(1);
      if (w_rd_push && !w_rd_pop)      r_rd_cnt <= r_rd_cnt + CW'(1);
      else if (!w_rd_push && w_rd_pop) r_rd_cnt <= r_rd_cnt - CW'(1);
    end
  end

  // ---------------------------------------------------------------------------------------
  // Read beat expander: Idle pops a due head and emits beat 0; Burst emits the rest.
  // ---------------------------------------------------------------------------------------
  exp_state_e  r_state, w_state_nxt;
  logic [41:0] r_bst_addr;
  logic [1:0]  r_bst_len, r_bst_nxt;
  logic [15:0] r_bst_mdata;
  logic        w_beat_valid;
  logic [41:0] w_beat_addr;
  logic [1:0]  w_beat_num;
  logic [15:0] w_beat_mdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_rd_due && (w_rd_head.len != 2'd0)) w_state_nxt = StBurst;
      StBurst: if (r_bst_nxt == r_bst_len)              w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_rd_pop     = 1'b0;
    w_beat_valid = 1'b0;
    w_beat_addr  = '0;
    w_beat_num   = '0;
    w_beat_mdata = '0;
    unique case (r_state)
      StIdle: begin
        if (w_rd_due) begin
          w_rd_pop     = 1'b1;
          w_beat_valid = 1'b1;
          w_beat_addr  = w_rd_head.addr;
          w_beat_mdata = w_rd_head.mdata;
        end
      end
      StBurst: begin
        w_beat_valid = 1'b1;
        w_beat_addr  = r_bst_addr;
        w_beat_num   = r_bst_nxt;
        w_beat_mdata = r_bst_mdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bst_addr  <= '0;
      r_bst_len   <= '0;
      r_bst_nxt   <= '0;
      r_bst_mdata <= '0;
    end else if (w_rd_pop) begin
      r_bst_addr  <= w_rd_head.addr;
      r_bst_len   <= w_rd_head.len;
      r_bst_nxt   <= 2'd1;
      r_bst_mdata <= w_rd_head.mdata;
    end else if (r_state == StBurst) begin
      r_bst_nxt   <= r_bst_nxt + 2'd1;
    end
  end

  logic        r_rsp_valid;
  logic [41:0] r_rsp_line;
  logic [1:0]  r_rsp_num;
  logic [15:0] r_rsp_mdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_line  <= '0;
      r_rsp_num   <= '0;
      r_rsp_mdata <= '0;
    end else begin
      r_rsp_valid <= w_beat_valid;
      r_rsp_line  <= w_beat_addr + 42'(w_beat_num);
      r_rsp_num   <= w_beat_num;
      r_rsp_mdata <= w_beat_mdata;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Write path: count beats, queue one entry per complete request, ack once due.
  // ---------------------------------------------------------------------------------------
  logic          r_wr_busy;
  logic [1:0]    r_wr_cnt, r_wr_len;
  logic [15:0]   r_wr_mdata;
  logic [1:0]    w_c1_len;
  logic          w_wr_last, w_wr_full, w_wr_empty, w_wr_push, w_wr_pop, w_wr_bad_len;
  wr_ent_t       w_wr_new, w_wr_head;
  wr_ent_t       r_wr_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_wptr, r_wr_rptr;
  logic [CW-1:0] r_wr_cnt_q, w_wr_free;
  logic signed [15:0] w_wr_diff;

  assign w_c1_len     = (bus.c1_req_cl_len == 2'd2) ? 2'd0 : bus.c1_req_cl_len;
  assign w_wr_bad_len = bus.c1_req_valid && bus.c1_req_sop && (bus.c1_req_cl_len == 2'd2);
  assign w_wr_full    = (r_wr_cnt_q == DEPTH_C);
  assign w_wr_empty   = (r_wr_cnt_q == '0);
  assign w_wr_head    = r_wr_mem[r_wr_rptr];
  assign w_wr_diff    = r_now - w_wr_head.due;
  assign w_wr_pop     = !w_wr_empty && (w_wr_diff >= 0);
  assign w_wr_push    = w_wr_last && !w_wr_full;
  assign w_wr_free    = DEPTH_C - r_wr_cnt_q;

  // A sop beat always starts a fresh request, abandoning any partial one.
  always_comb begin
    w_wr_last = 1'b0;
    w_wr_new  = '{mdata: r_wr_mdata, len: r_wr_len, due: r_now + LAT_C};
    if (bus.c1_req_valid) begin
      if (bus.c1_req_sop) begin
        if (w_c1_len == 2'd0) begin
          w_wr_last      = 1'b1;
          w_wr_new.mdata = bus.c1_req_mdata;
          w_wr_new.len   = 2'd0;
        end
      end else if (r_wr_busy && (r_wr_cnt == r_wr_len)) begin
        w_wr_last = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_busy  <= 1'b0;
      r_wr_cnt   <= '0;
      r_wr_len   <= '0;
      r_wr_mdata <= '0;
    end else if (bus.c1_req_valid) begin
      if (bus.c1_req_sop) begin
        r_wr_busy  <= (w_c1_len != 2'd0);
        r_wr_cnt   <= 2'd1;
        r_wr_len   <= w_c1_len;
        r_wr_mdata <= bus.c1_req_mdata;
      end else if (r_wr_busy) begin
        if (r_wr_cnt == r_wr_len) r_wr_busy <= 1'b0;
        r_wr_cnt <= r_wr_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_push) r_wr_mem[r_wr_wptr] <= w_wr_new;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_wptr  <= '0;
      r_wr_rptr  <= '0;
      r_wr_cnt_q <= '0;
    end else begin
      if (w_wr_push) r_wr_wptr <= r_wr_wptr + AW'(1);
      if (w_wr_pop)  r_wr_rptr <= r_wr_rptr + AW'(1);
      if (w_wr_push && !w_wr_pop)      r_wr_cnt_q <= r_wr_cnt_q + CW'(1);
      else if (!w_wr_push && w_wr_pop) r_wr_cnt_q <= r_wr_cnt_q - CW'(1);
    end
  end

  logic        r_ack_valid;
  logic [15:0] r_ack_mdata;
  logic [1:0]  r_ack_len;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack_valid <= 1'b0;
      r_ack_mdata <= '0;
      r_ack_len   <= '0;
    end else begin
      r_ack_valid <= w_wr_pop;
      r_ack_mdata <= w_wr_pop ? w_wr_head.mdata : 16'd0;
      r_ack_len   <= w_wr_pop ? w_wr_head.len   : 2'd0;
    end
  end

  // Sticky protocol/overflow error, cleared only by reset.
  logic r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if ((bus.c0_req_valid && w_rd_full) || (w_wr_last && w_wr_full) ||
                 w_rd_bad_len || w_wr_bad_len) begin
      r_err <= 1'b1;
    end
  end

  assign bus.c0_tx_alm_full = (w_rd_free <= TH_C);
  assign bus.c1_tx_alm_full = (w_wr_free <= TH_C);
  assign bus.c0_rsp_valid   = r_rsp_valid;
  assign bus.c0_rsp_mdata   = r_rsp_mdata;
  assign bus.c0_rsp_cl_num  = r_rsp_num;
  assign bus.c0_rsp_data    = {8{{22'd0, r_rsp_line}}};
  assign bus.c1_rsp_valid   = r_ack_valid;
  assign bus.c1_rsp_mdata   = r_ack_mdata;
  assign bus.c1_rsp_cl_num  = r_ack_len;
  assign bus.err_overflow   = r_err;

endmodule

// File: tb/tb_ofs_plat_host_chan_xgroupx_fiu_stub_responder.sv
// Scoreboard bench for the FIU stub responder: drivers queue expected beats/acks with their
// exact arrival cycle; forked monitors pop and compare whenever a response is presented.
module tb_ofs_plat_host_chan_xgroupx_fiu_stub_responder;

  localparam int LAT_A = 8;
  localparam int LAT_B = 100;

  typedef struct {
    int          cyc;
    logic [15:0] mdata;
    logic [1:0]  cl;
    logic [41:0] line;
  } rd_exp_t;

  typedef struct {
    int          cyc;
    logic [15:0] mdata;
    logic [1:0]  cl;
  } wr_exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tb_cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   rd_free_a = 0;
  int   rd_free_b = 0;
  int   wr_free_a = 0;

  rd_exp_t qa[$];
  rd_exp_t qb[$];
  wr_exp_t qw[$];

  ofs_plat_host_chan_xgroupx_fiu_stub_responder_if bus_a ();
  ofs_plat_host_chan_xgroupx_fiu_stub_responder_if bus_b ();

  ofs_plat_host_chan_xgroupx_fiu_stub_responder #(
    .RSP_LATENCY (LAT_A), .FIFO_DEPTH (64), .ALM_FULL_TH (8)
  ) u_dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  ofs_plat_host_chan_xgroupx_fiu_stub_responder #(
    .RSP_LATENCY (LAT_B), .FIFO_DEPTH (64), .ALM_FULL_TH (8)
  ) u_dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, tb_cyc);
    end
  endtask

  // Expected read beats: a burst starts when due, but never before the previous burst ends.
  task automatic exp_rd(bit sel_b, int n, logic [41:0] addr, logic [1:0] len, logic [15:0] md);
    int s;
    int lat;
    int fr;
    rd_exp_t e;
    lat = sel_b ? LAT_B : LAT_A;
    fr  = sel_b ? rd_free_b : rd_free_a;
    s   = (n + lat + 1 > fr) ? n + lat + 1 : fr;
    for (int i = 0; i <= int'(len); i++) begin
      e.cyc = s + i;
      e.mdata = md;
      e.cl = 2'(i);
      e.line = addr + 42'(i);
      if (sel_b) qb.push_back(e);
      else       qa.push_back(e);
    end
    if (sel_b) rd_free_b = s + int'(len) + 1;
    else       rd_free_a = s + int'(len) + 1;
  endtask

  task automatic exp_wr(int n, logic [15:0] md, logic [1:0] len);
    wr_exp_t e;
    e.cyc = (n + LAT_A + 1 > wr_free_a) ? n + LAT_A + 1 : wr_free_a;
    e.mdata = md;
    e.cl = len;
    qw.push_back(e);
    wr_free_a = e.cyc + 1;
  endtask

  task automatic drv_rd(logic [41:0] addr, logic [1:0] cl, logic [15:0] md);
    @(negedge clk);
    bus_a.c0_req_valid = 1'b1;
    bus_a.c0_req_addr = addr;
    bus_a.c0_req_cl_len = cl;
    bus_a.c0_req_mdata = md;
    bus_a.c1_req_valid = 1'b0;
  endtask

  task automatic drv_wr(logic sop, logic [1:0] cl, logic [15:0] md);
    @(negedge clk);
    bus_a.c0_req_valid = 1'b0;
    bus_a.c1_req_valid = 1'b1;
    bus_a.c1_req_sop = sop;
    bus_a.c1_req_cl_len = cl;
    bus_a.c1_req_mdata = md;
  endtask

  task automatic idle(int k);
    repeat (k) begin
      @(negedge clk);
      bus_a.c0_req_valid = 1'b0;
      bus_a.c1_req_valid = 1'b0;
      bus_b.c0_req_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(string nm, int budget);
    int k = 0;
    while ((qa.size() + qb.size() + qw.size() != 0) && k < budget) begin
      idle(1);
      k++;
    end
    #1;
    chk(nm, 64'(qa.size() + qb.size() + qw.size()), 64'd0);
  endtask

  task automatic mon_rd(bit sel_b);
    rd_exp_t e;
    logic v;
    logic [15:0] md;
    logic [1:0] cl;
    logic [511:0] d;
    forever begin
      @(negedge clk);
      v  = sel_b ? bus_b.c0_rsp_valid  : bus_a.c0_rsp_valid;
      md = sel_b ? bus_b.c0_rsp_mdata  : bus_a.c0_rsp_mdata;
      cl = sel_b ? bus_b.c0_rsp_cl_num : bus_a.c0_rsp_cl_num;
      d  = sel_b ? bus_b.c0_rsp_data   : bus_a.c0_rsp_data;
      if (sel_b) chk("b_no_write_ack", 64'(bus_b.c1_rsp_valid), 64'd0);
      if (v) begin
        if ((sel_b ? qb.size() : qa.size()) == 0) begin
          chk(sel_b ? "b_rd_unexpected" : "a_rd_unexpected", 64'(md), 64'hDEAD_0000);
        end else begin
          e = sel_b ? qb.pop_front() : qa.pop_front();
          chk("rd_cycle", 64'(tb_cyc), 64'(e.cyc));
          chk("rd_mdata", 64'(md), 64'(e.mdata));
          chk("rd_cl_num", 64'(cl), 64'(e.cl));
          for (int k = 0; k < 8; k++) chk("rd_data_lane", d[64*k +: 64], {22'd0, e.line});
        end
      end
    end
  endtask

  task automatic mon_wr();
    wr_exp_t e;
    forever begin
      @(negedge clk);
      if (bus_a.c1_rsp_valid) begin
        if (qw.size() == 0) begin
          chk("wr_unexpected", 64'(bus_a.c1_rsp_mdata), 64'hDEAD_0000);
        end else begin
          e = qw.pop_front();
          chk("wr_cycle", 64'(tb_cyc), 64'(e.cyc));
          chk("wr_mdata", 64'(bus_a.c1_rsp_mdata), 64'(e.mdata));
          chk("wr_cl_num", 64'(bus_a.c1_rsp_cl_num), 64'(e.cl));
        end
      end
    end
  endtask

  initial begin
    int n;
    bus_a.c0_req_valid = 1'b0; bus_a.c0_req_addr = '0; bus_a.c0_req_cl_len = '0;
    bus_a.c0_req_mdata = '0;   bus_a.c1_req_valid = 1'b0; bus_a.c1_req_sop = 1'b0;
    bus_a.c1_req_cl_len = '0;  bus_a.c1_req_mdata = '0;
    bus_b.c0_req_valid = 1'b0; bus_b.c0_req_addr = '0; bus_b.c0_req_cl_len = '0;
    bus_b.c0_req_mdata = '0;   bus_b.c1_req_valid = 1'b0; bus_b.c1_req_sop = 1'b0;
    bus_b.c1_req_cl_len = '0;  bus_b.c1_req_mdata = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_c0_rsp_valid", 64'(bus_a.c0_rsp_valid), 64'd0);
    chk("rst_c1_rsp_valid", 64'(bus_a.c1_rsp_valid), 64'd0);
    chk("rst_c0_alm_full", 64'(bus_a.c0_tx_alm_full), 64'd0);
    chk("rst_c1_alm_full", 64'(bus_a.c1_tx_alm_full), 64'd0);
    chk("rst_err", 64'(bus_a.err_overflow), 64'd0);
    chk("rst_data", bus_a.c0_rsp_data[63:0], 64'd0);
    chk("rst_b_valid", 64'(bus_b.c0_rsp_valid), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    fork
      mon_rd(1'b0);
      mon_rd(1'b1);
      mon_wr();
    join_none

    idle(2);

    // Single read, one beat exactly 8 cycles after acceptance.
    drv_rd(42'h100, 2'd0, 16'hA5);
    exp_rd(1'b0, tb_cyc, 42'h100, 2'd0, 16'hA5);
    idle(1);
    wait_drain("single_read_drain", 40);

    // 4-line read at the top of the address space wraps to 0,1,2.
    drv_rd(42'h3FF_FFFF_FFFF, 2'd3, 16'h1234);
    exp_rd(1'b0, tb_cyc, 42'h3FF_FFFF_FFFF, 2'd3, 16'h1234);
    idle(1);
    wait_drain("wrap_read_drain", 40);

    // 4-line write: one ack, 8 cycles after the last beat, cl_num=3.
    drv_wr(1'b1, 2'd3, 16'h77);
    drv_wr(1'b0, 2'd0, 16'h0);
    drv_wr(1'b0, 2'd0, 16'h0);
    drv_wr(1'b0, 2'd0, 16'h0);
    exp_wr(tb_cyc, 16'h77, 2'd3);
    idle(1);
    wait_drain("write4_drain", 40);

    // A new sop mid-write abandons the partial request.
    drv_wr(1'b1, 2'd3, 16'h11);
    drv_wr(1'b1, 2'd0, 16'h22);
    exp_wr(tb_cyc, 16'h22, 2'd0);
    idle(1);
    wait_drain("restart_drain", 40);
    #1;
    chk("err_after_legal", 64'(bus_a.err_overflow), 64'd0);

    // Back-to-back reads and 2-line writes every cycle for 1000 cycles.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      bus_a.c0_req_valid = 1'b1;
      bus_a.c0_req_addr = 42'(i * 3);
      bus_a.c0_req_cl_len = 2'd0;
      bus_a.c0_req_mdata = 16'(i);
      exp_rd(1'b0, tb_cyc, 42'(i * 3), 2'd0, 16'(i));
      bus_a.c1_req_valid = 1'b1;
      bus_a.c1_req_sop = (i % 2 == 0);
      bus_a.c1_req_cl_len = 2'd1;
      bus_a.c1_req_mdata = 16'(i);
      if (i % 2 == 1) exp_wr(tb_cyc, 16'(i - 1), 2'd1);
    end
    idle(1);
    wait_drain("stream_drain", 60);
    #1;
    chk("stream_err", 64'(bus_a.err_overflow), 64'd0);

    // Illegal cl_len=2 is served as one line and flags the error.
    drv_rd(42'h55, 2'd2, 16'h5A);
    exp_rd(1'b0, tb_cyc, 42'h55, 2'd0, 16'h5A);
    idle(1);
    wait_drain("len2_drain", 40);
    chk("len2_err", 64'(bus_a.err_overflow), 64'd1);

    // Reset during a 4-beat burst, after two beats have been seen.
    drv_rd(42'h200, 2'd3, 16'hBEEF);
    n = tb_cyc;
    exp_rd(1'b0, n, 42'h200, 2'd3, 16'hBEEF);
    idle(1);
    while (tb_cyc < n + LAT_A + 2) idle(1);
    #2;
    reset_n = 1'b0;
    qa.delete();
    rd_free_a = 0;
    #1;
    chk("midrst_valid", 64'(bus_a.c0_rsp_valid), 64'd0);
    chk("midrst_cl_num", 64'(bus_a.c0_rsp_cl_num), 64'd0);
    chk("midrst_data", bus_a.c0_rsp_data[63:0], 64'd0);
    chk("midrst_err", 64'(bus_a.err_overflow), 64'd0);
    idle(3);
    reset_n = 1'b1;
    idle(20);
    drv_rd(42'h300, 2'd0, 16'h0C0C);
    exp_rd(1'b0, tb_cyc, 42'h300, 2'd0, 16'h0C0C);
    idle(1);
    wait_drain("post_reset_drain", 40);

    // Overflow on the long-latency instance: 70 back-to-back reads, 64 survive.
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      #1;
      chk("ovf_alm_full", 64'(bus_b.c0_tx_alm_full), 64'(i >= 56));
      chk("ovf_err", 64'(bus_b.err_overflow), 64'(i >= 65));
      bus_b.c0_req_valid = 1'b1;
      bus_b.c0_req_addr = 42'(16'h400 + i);
      bus_b.c0_req_cl_len = 2'd0;
      bus_b.c0_req_mdata = 16'(i);
      if (i < 64) exp_rd(1'b1, tb_cyc, 42'(16'h400 + i), 2'd0, 16'(i));
    end
    idle(1);
    #1;
    chk("ovf_err_final", 64'(bus_b.err_overflow), 64'd1);
    chk("ovf_alm_final", 64'(bus_b.c0_tx_alm_full), 64'd1);
    wait_drain("ovf_drain", 300);
    chk("ovf_alm_drained", 64'(bus_b.c0_tx_alm_full), 64'd0);
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
